// File: rtl/vga_fb_arbiter.sv
// Framebuffer RAM arbiter: scan-out reads always take the slot, draw writes queue in a FIFO and drain in gaps.
// Define FB_ARB_STATS_EN to build the saturating write-stall counter on wr_stall_cnt.
module vga_fb_arbiter #(
  parameter int ADDR_W     = 15,
  parameter int DATA_W     = 3,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_valid,
  output logic [DATA_W-1:0] disp_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_idle,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [15:0]       wr_stall_cnt
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] PTR_ONE = {{PTR_W{1'b0}}, 1'b1};

  localparam logic [1:0] SLOT_IDLE  = 2'd0;
  localparam logic [1:0] SLOT_READ  = 2'd1;
  localparam logic [1:0] SLOT_WRITE = 2'd2;

  logic [ADDR_W-1:0] fifo_addr_r [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data_r [FIFO_DEPTH];
  logic [PTR_W:0]    wr_ptr_r;
  logic [PTR_W:0]    rd_ptr_r;
  logic              full_s;
  logic              empty_s;
  logic              push_s;
  logic              pop_s;
  logic [1:0]        slot_s;
  logic [1:0]        rd_vld_r;

  // Extra pointer MSB distinguishes full (wrapped once) from empty
  assign empty_s  = (wr_ptr_r == rd_ptr_r);
  assign full_s   = (wr_ptr_r[PTR_W] != rd_ptr_r[PTR_W]) &&
                    (wr_ptr_r[PTR_W-1:0] == rd_ptr_r[PTR_W-1:0]);
  assign push_s   = wr_valid && !full_s;
  assign pop_s    = (slot_s == SLOT_WRITE);
  assign wr_ready = !full_s;
  assign wr_idle  = empty_s && !mem_we;

  // Slot selection: display fetch first, then queued write, else idle
  always_comb begin
    slot_s = SLOT_IDLE;
    if (disp_req) begin
      slot_s = SLOT_READ;
    end else if (!empty_s) begin
      slot_s = SLOT_WRITE;
    end else begin
      slot_s = SLOT_IDLE;
    end
  end

  // Write FIFO storage and pointers; full is judged before this cycle's pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_addr_r[i] <= '0;
        fifo_data_r[i] <= '0;
      end
    end else begin
      if (push_s) begin
        fifo_addr_r[wr_ptr_r[PTR_W-1:0]] <= wr_addr;
        fifo_data_r[wr_ptr_r[PTR_W-1:0]] <= wr_data;
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
    end
  end

  // Registered RAM command; address and write data hold through idle slots
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      case (slot_s)
        SLOT_READ: begin
          mem_en   <= 1'b1;
          mem_we   <= 1'b0;
          mem_addr <= disp_addr;
        end
        SLOT_WRITE: begin
          mem_en    <= 1'b1;
          mem_we    <= 1'b1;
          mem_addr  <= fifo_addr_r[rd_ptr_r[PTR_W-1:0]];
          mem_wdata <= fifo_data_r[rd_ptr_r[PTR_W-1:0]];
        end
        default: begin
          mem_en <= 1'b0;
          mem_we <= 1'b0;
        end
      endcase
    end
  end

  // Read return pipe: request -> RAM command -> RAM data -> display output
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_vld_r   <= 2'b00;
      disp_valid <= 1'b0;
      disp_data  <= '0;
    end else begin
      rd_vld_r   <= {rd_vld_r[0], disp_req};
      disp_valid <= rd_vld_r[1];
      if (rd_vld_r[1]) begin
        disp_data <= mem_rdata;
      end else begin
        disp_data <= disp_data;
      end
    end
  end

`ifdef FB_ARB_STATS_EN
  logic [15:0] stall_cnt_r;

  // Saturating count of cycles where a queued write lost the slot to a fetch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_r <= 16'h0000;
    end else if (disp_req && !empty_s && (stall_cnt_r != 16'hFFFF)) begin
      stall_cnt_r <= stall_cnt_r + 16'h0001;
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign wr_stall_cnt = stall_cnt_r;
`else
  assign wr_stall_cnt = 16'h0000;
`endif

endmodule
